// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad matrix scanner.
// Holds the scan FSM encoding and default matrix geometry.
package keypad_pkg;

  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 8;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    EMIT,
    NEXT
  } scan_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Per-key debouncer: stable level plus a run counter of
// consecutive samples that disagree with it.
module key_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic clk,
  input  logic resetn,
  input  logic raw,
  input  logic sample_en,
  output logic stable,
  output logic flip
);

  localparam int CW = idx_w(DEBOUNCE_SCANS + 1);

  logic [CW-1:0] cnt;
  logic          hit;

  assign hit  = (cnt == CW'(DEBOUNCE_SCANS - 1));
  assign flip = sample_en && (raw != stable) && hit;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (sample_en) begin
      if (raw == stable) begin
        cnt <= '0;
      end else if (hit) begin
        stable <= raw;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Autonomous row-scanning keypad reader with per-key debounce
// and a valid/ready press/release event stream.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int             ROWS           = KP_ROWS,
  parameter int             COLS           = KP_COLS,
  parameter int             SETTLE_CYCLES  = 50,
  parameter int             DEBOUNCE_SCANS = 3,
  parameter logic [ROWS-1:0] ROW_REVERSE   = ROWS'(4'b1100)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          enable,
  input  logic [COLS-1:0]               column_data,
  output logic [ROWS-1:0]               row_data,
  output logic [ROWS*COLS-1:0]          key_state,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [$clog2(ROWS*COLS)-1:0]  evt_key,
  output logic                          evt_press,
  output logic                          scan_done
);

  localparam int KEYS  = ROWS * COLS;
  localparam int KEY_W = $clog2(KEYS);
  localparam int ROW_W = idx_w(ROWS);
  localparam int COL_W = idx_w(COLS);
  localparam int SET_W = idx_w(SETTLE_CYCLES);

  scan_state_t      state, state_nx;
  logic [ROW_W-1:0] row;
  logic [SET_W-1:0] settle;
  logic [COLS-1:0]  mask, mask_nx;
  logic [COLS-1:0]  raw;
  logic [COLS-1:0]  row_flips;
  logic [KEYS-1:0]  flips;
  logic [COL_W-1:0] lsb;
  logic [ROWS-1:0]  row_drive;
  logic             settle_last;
  logic             fire;
  int               key_idx;

  // Mirrored rows are remapped here so key_state is in logical order.
  always_comb begin
    raw = '0;
    for (int c = 0; c < COLS; c++) begin
      raw[c] = ROW_REVERSE[row] ? ~column_data[COLS-1-c]
                                : ~column_data[c];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      key_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
      ) u_db (
        .clk      (clk),
        .resetn   (resetn),
        .raw      (raw[c]),
        .sample_en((state == SAMPLE) && (row == ROW_W'(r))),
        .stable   (key_state[r*COLS+c]),
        .flip     (flips[r*COLS+c])
      );
    end
  end

  assign row_flips   = flips[int'(row)*COLS +: COLS];
  assign row_drive   = ~(ROWS'(1) << row);
  assign settle_last = (settle == SET_W'(SETTLE_CYCLES - 1));

  always_comb begin
    lsb = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (mask[c]) lsb = COL_W'(c);
    end
  end

  assign key_idx   = int'(row) * COLS + int'(lsb);
  assign fire      = evt_valid && evt_ready;
  assign evt_key   = evt_valid ? KEY_W'(key_idx) : '0;
  assign evt_press = evt_valid && key_state[key_idx];

  always_comb begin
    state_nx  = state;
    row_data  = '1;
    evt_valid = 1'b0;
    scan_done = 1'b0;
    mask_nx   = mask;
    unique case (state)
      IDLE: begin
        if (enable) state_nx = DRIVE;
      end
      DRIVE: begin
        row_data = row_drive;
        if (settle_last) state_nx = SAMPLE;
      end
      SAMPLE: begin
        row_data = row_drive;
        state_nx = (|row_flips) ? EMIT : NEXT;
      end
      EMIT: begin
        row_data  = row_drive;
        evt_valid = |mask;
        if (fire) mask_nx[lsb] = 1'b0;
        if (!(|mask_nx)) state_nx = NEXT;
      end
      NEXT: begin
        scan_done = (row == ROW_W'(ROWS - 1));
        state_nx  = enable ? DRIVE : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      row    <= '0;
      settle <= '0;
      mask   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          row    <= '0;
          settle <= '0;
        end
        DRIVE:  settle <= settle_last ? '0 : settle + 1'b1;
        SAMPLE: mask <= row_flips;
        EMIT:   mask <= mask_nx;
        NEXT: begin
          row <= (row == ROW_W'(ROWS - 1)) ? '0 : row + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Self-checking bench: matrix model, per-key debounce reference
// model and event scoreboard for keypad_matrix_scanner.
module tb_keypad_matrix_scanner;

  localparam int ROWS = 4;
  localparam int COLS = 8;
  localparam int SETTLE = 4;
  localparam int DEB = 3;
  localparam int KEYS = ROWS * COLS;
  localparam int KW = $clog2(KEYS);
  localparam logic [ROWS-1:0] REV = 4'b1100;

  typedef struct {
    int key;
    bit press;
    int cyc;
  } ev_t;

  logic clk;
  logic resetn;
  logic enable;
  logic [COLS-1:0] column_data;
  logic [ROWS-1:0] row_data;
  logic [KEYS-1:0] key_state;
  logic evt_valid;
  logic evt_ready;
  logic [KW-1:0] evt_key;
  logic evt_press;
  logic scan_done;

  bit pressed[ROWS][COLS];
  bit m_stable[KEYS];
  int m_cnt[KEYS];
  ev_t obs[$];
  ev_t exp_q[$];
  int cyc;
  int rows_seen;
  bit rand_rdy;
  int n_cmp;
  int n_bad;
  logic [ROWS-1:0] prev_rd;

  keypad_matrix_scanner #(
    .ROWS(ROWS),
    .COLS(COLS),
    .SETTLE_CYCLES(SETTLE),
    .DEBOUNCE_SCANS(DEB),
    .ROW_REVERSE(REV)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .enable(enable),
    .column_data(column_data),
    .row_data(row_data),
    .key_state(key_state),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_key(evt_key),
    .evt_press(evt_press),
    .scan_done(scan_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical matrix: a closed key pulls its column low
  // only while its row is driven low.
  always_comb begin
    column_data = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (pressed[r][c] && !row_data[r]) column_data[c] = 1'b0;
  end

  task automatic model_row(input int r);
    for (int m = 0; m < COLS; m++) begin
      int c;
      int k;
      bit rv;
      c = REV[r] ? COLS - 1 - m : m;
      k = r * COLS + m;
      rv = pressed[r][c];
      if (rv == m_stable[k]) begin
        m_cnt[k] = 0;
      end else begin
        m_cnt[k]++;
        if (m_cnt[k] == DEB) begin
          m_stable[k] = rv;
          m_cnt[k] = 0;
          exp_q.push_back('{k, rv, 0});
        end
      end
    end
  endtask

  initial begin
    cyc = 0;
    rows_seen = 0;
    prev_rd = '1;
    forever begin
      @(negedge clk);
      cyc++;
      if (!resetn) begin
        prev_rd = '1;
      end else begin
        if (evt_valid && evt_ready)
          obs.push_back('{int'(evt_key), evt_press, cyc});
        if (prev_rd == '1 && row_data != '1) begin
          int ri;
          ri = 0;
          for (int r = 0; r < ROWS; r++)
            if (!row_data[r]) ri = r;
          rows_seen++;
          model_row(ri);
        end
        prev_rd = row_data;
      end
    end
  end

  task automatic reset_model();
    for (int k = 0; k < KEYS; k++) begin
      m_stable[k] = 0;
      m_cnt[k] = 0;
    end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        pressed[r][c] = 0;
    exp_q.delete();
    obs.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) evt_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_sweep();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!scan_done && n < 2000);
    if (!scan_done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sweep_timeout got=no_scan_done want=scan_done");
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    enable = 1'b0;
    evt_ready = 1'b1;
    rand_rdy = 0;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    bit bad_rd;
    bit bad_v;
    resetn = 1'b0;
    enable = 1'b0;
    evt_ready = 1'b1;
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({row_data, key_state, evt_valid, evt_key, evt_press, scan_done}
        !== {4'b1111, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_values got rd=%b ks=%h v=%b k=%0d p=%b sd=%b",
               row_data, key_state, evt_valid, evt_key, evt_press,
               scan_done);
    end
    resetn = 1'b1;
    bad_rd = 0;
    bad_v = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (row_data !== 4'b1111) bad_rd = 1;
      if (evt_valid !== 1'b0 || scan_done !== 1'b0) bad_v = 1;
    end
    n_cmp++;
    if (bad_rd) begin
      n_bad++;
      $display("FAIL idle_row_data got=%b want=1111", row_data);
    end
    n_cmp++;
    if (bad_v) begin
      n_bad++;
      $display("FAIL idle_outputs got valid/done activity want=none");
    end
    n_cmp++;
    if (key_state !== '0) begin
      n_bad++;
      $display("FAIL idle_key_state got=%h want=0", key_state);
    end
  endtask

  task automatic test_single_press();
    do_reset();
    enable = 1'b1;
    wait_sweep();
    pressed[1][2] = 1;
    wait_sweep();
    wait_sweep();
    n_cmp++;
    if (key_state[10] !== 1'b0) begin
      n_bad++;
      $display("FAIL press_early got=%b want=0", key_state[10]);
    end
    wait_sweep();
    n_cmp++;
    if (key_state !== 32'h0000_0400) begin
      n_bad++;
      $display("FAIL press_state got=%h want=00000400", key_state);
    end
    n_cmp++;
    if (obs.size() != 1 || obs[0].key != 10 || obs[0].press != 1) begin
      n_bad++;
      $display("FAIL press_event got n=%0d want n=1 key=10 press=1",
               obs.size());
    end
    pressed[1][2] = 0;
    repeat (3) wait_sweep();
    n_cmp++;
    if (obs.size() != 2 || obs[1].key != 10 || obs[1].press != 0 ||
        key_state !== '0) begin
      n_bad++;
      $display("FAIL release_event got n=%0d ks=%h want n=2 key=10 rel",
               obs.size(), key_state);
    end
  endtask

  task automatic test_mirror();
    do_reset();
    enable = 1'b1;
    wait_sweep();
    pressed[2][0] = 1;
    pressed[3][7] = 1;
    repeat (3) wait_sweep();
    n_cmp++;
    if (obs.size() != 2 || obs[0].key != 23 || obs[1].key != 24 ||
        !obs[0].press || !obs[1].press) begin
      n_bad++;
      $display("FAIL mirror_events got n=%0d k0=%0d k1=%0d want 23,24",
               obs.size(), obs.size() > 0 ? obs[0].key : -1,
               obs.size() > 1 ? obs[1].key : -1);
    end
    n_cmp++;
    if (key_state !== 32'h0180_0000) begin
      n_bad++;
      $display("FAIL mirror_state got=%h want=01800000", key_state);
    end
  endtask

  task automatic test_bounce();
    int r;
    int c;
    do_reset();
    enable = 1'b1;
    wait_sweep();
    r = $urandom_range(0, ROWS - 1);
    c = $urandom_range(0, COLS - 1);
    for (int i = 0; i < 10; i++) begin
      pressed[r][c] = (i % 2 == 0);
      wait_sweep();
    end
    n_cmp++;
    if (obs.size() != 0 || key_state !== '0) begin
      n_bad++;
      $display("FAIL bounce got n=%0d ks=%h want n=0 ks=0",
               obs.size(), key_state);
    end
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    enable = 1'b1;
    evt_ready = 1'b0;
    wait_sweep();
    pressed[0][1] = 1;
    pressed[0][4] = 1;
    pressed[0][6] = 1;
    n = 0;
    while (!evt_valid && n < 500) begin
      step();
      n++;
    end
    n_cmp++;
    if (!evt_valid) begin
      n_bad++;
      $display("FAIL bp_wait got valid=0 want valid=1");
    end
    for (int i = 0; i < 20; i++) begin
      step();
      n_cmp++;
      if (evt_valid !== 1'b1 || evt_key !== 5'd1 || evt_press !== 1'b1 ||
          row_data !== 4'b1110) begin
        n_bad++;
        $display("FAIL bp_hold got v=%b k=%0d p=%b rd=%b want 1,1,1,1110",
                 evt_valid, evt_key, evt_press, row_data);
      end
    end
    evt_ready = 1'b1;
    n = 0;
    while (row_data !== 4'b1101 && n < 50) begin
      step();
      n++;
    end
    n_cmp++;
    if (obs.size() != 3 || obs[0].key != 1 || obs[1].key != 4 ||
        obs[2].key != 6) begin
      n_bad++;
      $display("FAIL bp_order got n=%0d want keys 1,4,6", obs.size());
    end else begin
      n_cmp++;
      if (obs[1].cyc != obs[0].cyc + 1 || obs[2].cyc != obs[1].cyc + 1) begin
        n_bad++;
        $display("FAIL bp_b2b got cyc=%0d,%0d,%0d want consecutive",
                 obs[0].cyc, obs[1].cyc, obs[2].cyc);
      end
    end
    n_cmp++;
    if (row_data !== 4'b1101) begin
      n_bad++;
      $display("FAIL bp_advance got rd=%b want=1101", row_data);
    end
  endtask

  task automatic test_random();
    logic [KEYS-1:0] want;
    do_reset();
    enable = 1'b1;
    rand_rdy = 1;
    wait_sweep();
    for (int s = 0; s < 40; s++) begin
      int nch;
      nch = $urandom_range(0, 3);
      for (int j = 0; j < nch; j++) begin
        int r;
        int c;
        r = $urandom_range(0, ROWS - 1);
        c = $urandom_range(0, COLS - 1);
        pressed[r][c] = !pressed[r][c];
      end
      wait_sweep();
      for (int k = 0; k < KEYS; k++) want[k] = m_stable[k];
      n_cmp++;
      if (key_state !== want) begin
        n_bad++;
        $display("FAIL rand_state sweep=%0d got=%h want=%h",
                 s, key_state, want);
      end
    end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        pressed[r][c] = 0;
    repeat (DEB + 1) wait_sweep();
    n_cmp++;
    if (key_state !== '0) begin
      n_bad++;
      $display("FAIL rand_release got=%h want=0", key_state);
    end
    n_cmp++;
    if (obs.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL rand_count got=%0d want=%0d", obs.size(), exp_q.size());
    end else begin
      for (int i = 0; i < obs.size(); i++) begin
        n_cmp++;
        if (obs[i].key != exp_q[i].key || obs[i].press != exp_q[i].press) begin
          n_bad++;
          $display("FAIL rand_event i=%0d got=%0d/%0d want=%0d/%0d", i,
                   obs[i].key, obs[i].press, exp_q[i].key, exp_q[i].press);
        end
      end
    end
    rand_rdy = 0;
    evt_ready = 1'b1;
  endtask

  task automatic test_wrap_async_reset();
    int pulses;
    int t;
    int last_t;
    int base;
    int n;
    bit bad_gap;
    do_reset();
    enable = 1'b1;
    wait_sweep();
    base = rows_seen;
    pulses = 0;
    t = 0;
    last_t = 0;
    bad_gap = 0;
    while (pulses < 5 && t < 1000) begin
      step();
      t++;
      if (scan_done) begin
        pulses++;
        if (t - last_t != ROWS * (SETTLE + 2)) bad_gap = 1;
        last_t = t;
      end
    end
    n_cmp++;
    if (pulses != 5 || rows_seen - base != 5 * ROWS) begin
      n_bad++;
      $display("FAIL wrap_pulses got=%0d rows=%0d want=5 rows=%0d",
               pulses, rows_seen - base, 5 * ROWS);
    end
    n_cmp++;
    if (bad_gap) begin
      n_bad++;
      $display("FAIL wrap_period got gap!=%0d want=%0d",
               ROWS * (SETTLE + 2), ROWS * (SETTLE + 2));
    end
    evt_ready = 1'b0;
    pressed[0][3] = 1;
    n = 0;
    while (!evt_valid && n < 500) begin
      step();
      n++;
    end
    n_cmp++;
    if (evt_valid !== 1'b1 || key_state[3] !== 1'b1) begin
      n_bad++;
      $display("FAIL arst_pre got v=%b ks3=%b want 1,1",
               evt_valid, key_state[3]);
    end
    #2;
    resetn = 1'b0;
    #1;
    n_cmp++;
    if (evt_valid !== 1'b0 || key_state !== '0 || row_data !== 4'b1111 ||
        evt_key !== '0) begin
      n_bad++;
      $display("FAIL arst_now got v=%b ks=%h rd=%b k=%0d want 0,0,1111,0",
               evt_valid, key_state, row_data, evt_key);
    end
    reset_model();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    evt_ready = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    resetn = 1'b1;
    enable = 1'b0;
    evt_ready = 1'b1;
    rand_rdy = 0;
    #2;
    test_reset();
    test_single_press();
    test_mirror();
    test_bounce();
    test_backpressure();
    test_random();
    test_wrap_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
